// File: rtl/umi_mem_arbiter_if.sv
// Bundled client-side and UMI-side request/response signals for umi_mem_arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface umi_mem_arbiter_if #(
   parameter int NUM_CLIENTS = 4,
   parameter int ADDR_WIDTH  = 64,
   parameter int DATA_WIDTH  = 576
) ();
   logic [NUM_CLIENTS-1:0]            client_req_valid;
   logic [NUM_CLIENTS-1:0]            client_req_iswrite;
   logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_req_addr;
   logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_req_data;
   logic [NUM_CLIENTS-1:0]            client_req_grant;
   logic [NUM_CLIENTS-1:0]            client_resp_valid;
   logic [DATA_WIDTH-1:0]             client_resp_data;

   logic                              mem_req_valid;
   logic                              mem_req_iswrite;
   logic [ADDR_WIDTH-1:0]             mem_req_addr;
   logic [DATA_WIDTH-1:0]             mem_req_data;
   logic                              mem_req_ready;
   logic                              mem_resp_valid;
   logic [DATA_WIDTH-1:0]             mem_resp_data;

   modport slave (
      input  client_req_valid, client_req_iswrite, client_req_addr, client_req_data,
      output client_req_grant, client_resp_valid, client_resp_data,
      output mem_req_valid, mem_req_iswrite, mem_req_addr, mem_req_data,
      input  mem_req_ready, mem_resp_valid, mem_resp_data
   );

   modport master (
      output client_req_valid, client_req_iswrite, client_req_addr, client_req_data,
      input  client_req_grant, client_resp_valid, client_resp_data,
      input  mem_req_valid, mem_req_iswrite, mem_req_addr, mem_req_data,
      output mem_req_ready, mem_resp_valid, mem_resp_data
   );
endinterface

// File: rtl/umi_mem_arbiter.sv
// Round-robin N-client arbiter onto one UMI port with a registered issue stage
// and an in-order tag FIFO that steers read responses back to their client.
module umi_mem_arbiter #(
   parameter int NUM_CLIENTS = 4,
   parameter int ADDR_WIDTH  = 64,
   parameter int DATA_WIDTH  = 576,
   parameter int TAG_DEPTH   = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   umi_mem_arbiter_if.slave               bus,
   output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding,
   output logic                           orphan_err
);
   localparam int IW = $clog2(NUM_CLIENTS);
   localparam int PW = $clog2(TAG_DEPTH);
   localparam int CW = $clog2(TAG_DEPTH+1);

   logic [ADDR_WIDTH-1:0]  req_addr [NUM_CLIENTS];
   logic [DATA_WIDTH-1:0]  req_data [NUM_CLIENTS];
   logic [NUM_CLIENTS-1:0] eligible;

   logic [IW-1:0]          rr_ptr;
   logic [IW-1:0]          gnt_idx;
   logic [IW-1:0]          cand;
   logic                   gnt_any;
   logic                   issue_free;
   logic                   push, pop;
   logic                   fifo_full;

   logic                   mreq_valid, mreq_iswrite;
   logic [ADDR_WIDTH-1:0]  mreq_addr;
   logic [DATA_WIDTH-1:0]  mreq_data;
   logic [NUM_CLIENTS-1:0] resp_valid;
   logic [DATA_WIDTH-1:0]  resp_data;

   logic [IW-1:0]          tag_mem [TAG_DEPTH];
   logic [PW-1:0]          wr_ptr, rd_ptr;
   logic [CW-1:0]          count;

   for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign req_addr[gi] = bus.client_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_data[gi] = bus.client_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // Full comes from registered occupancy so a same-cycle pop never frees a slot for a read.
   assign fifo_full  = (count == CW'(TAG_DEPTH));
   assign issue_free = !mreq_valid || bus.mem_req_ready;
   assign eligible   = bus.client_req_valid & (bus.client_req_iswrite | {NUM_CLIENTS{!fifo_full}});

   always_comb begin
      int j;
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      j       = 0;
      if (issue_free) begin
         for (int k = 0; k < NUM_CLIENTS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_CLIENTS) j = j - NUM_CLIENTS;
            cand = IW'(j);
            if (!gnt_any && eligible[cand]) begin
               gnt_any = 1'b1;
               gnt_idx = cand;
            end
         end
      end
   end

   assign bus.client_req_grant = gnt_any ? (NUM_CLIENTS'(1) << gnt_idx) : '0;
   assign push = gnt_any && !bus.client_req_iswrite[gnt_idx];
   assign pop  = bus.mem_resp_valid && (count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         mreq_valid   <= 1'b0;
         mreq_iswrite <= 1'b0;
         mreq_addr    <= '0;
         mreq_data    <= '0;
         rr_ptr       <= '0;
      end else if (issue_free) begin
         mreq_valid <= gnt_any;
         if (gnt_any) begin
            mreq_iswrite <= bus.client_req_iswrite[gnt_idx];
            mreq_addr    <= req_addr[gnt_idx];
            mreq_data    <= req_data[gnt_idx];
            rr_ptr       <= (gnt_idx == IW'(NUM_CLIENTS-1)) ? '0 : gnt_idx + IW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= gnt_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         orphan_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count      <= count + CW'(push) - CW'(pop);
         resp_valid <= pop ? (NUM_CLIENTS'(1) << tag_mem[rd_ptr]) : '0;
         if (pop) resp_data <= bus.mem_resp_data;
         if (bus.mem_resp_valid && (count == '0)) orphan_err <= 1'b1;
      end
   end

   assign bus.mem_req_valid     = mreq_valid;
   assign bus.mem_req_iswrite   = mreq_iswrite;
   assign bus.mem_req_addr      = mreq_addr;
   assign bus.mem_req_data      = mreq_data;
   assign bus.client_resp_valid = resp_valid;
   assign bus.client_resp_data  = resp_data;
   assign outstanding           = count;
endmodule

// File: tb/tb_umi_mem_arbiter.sv
// Directed bench for umi_mem_arbiter: single read, round robin, backpressure,
// tag-full blocking, response ordering with orphan, and reset mid-flight.
module tb_umi_mem_arbiter;
   localparam int NC = 4;
   localparam int AW = 64;
   localparam int DW = 576;
   localparam int TD = 16;

   logic       clk;
   logic       rst;
   logic [4:0] outstanding;
   logic       orphan_err;
   int         n_checks;
   int         n_fail;

   umi_mem_arbiter_if #(.NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   umi_mem_arbiter #(
      .NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .outstanding(outstanding),
      .orphan_err(orphan_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_client(input int i, input logic v, input logic w,
                             input logic [63:0] a, input logic [63:0] d);
      bus.client_req_valid[i]        = v;
      bus.client_req_iswrite[i]      = w;
      bus.client_req_addr[i*AW +: AW] = a;
      bus.client_req_data[i*DW +: DW] = DW'(d);
   endtask

   task automatic clear_clients();
      bus.client_req_valid   = '0;
      bus.client_req_iswrite = '0;
      bus.client_req_addr    = '0;
      bus.client_req_data    = '0;
   endtask

   logic [3:0] rr_exp [6];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clk      = 1'b0;
      rst      = 1'b1;
      clear_clients();
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      tick();
      tick();

      // reset state
      @(negedge clk);
      check_eq("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'h0);
      check_eq("rst_outstanding", 64'(outstanding), 64'h0);
      check_eq("rst_orphan", 64'(orphan_err), 64'h0);
      check_eq("rst_resp_valid", 64'(bus.client_resp_valid), 64'h0);
      check_eq("rst_grant", 64'(bus.client_req_grant), 64'h0);
      tick();
      rst = 1'b0;

      // single read from client 2
      set_client(2, 1'b1, 1'b0, 64'h40, 64'h0);
      @(negedge clk);
      check_eq("rd_grant", 64'(bus.client_req_grant), 64'h4);
      tick();
      clear_clients();
      check_eq("rd_mem_valid", 64'(bus.mem_req_valid), 64'h1);
      check_eq("rd_mem_addr", bus.mem_req_addr, 64'h40);
      check_eq("rd_mem_iswrite", 64'(bus.mem_req_iswrite), 64'h0);
      check_eq("rd_outstanding", 64'(outstanding), 64'h1);
      tick();
      check_eq("rd_mem_valid_clear", 64'(bus.mem_req_valid), 64'h0);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = DW'(64'hABCD);
      tick();
      bus.mem_resp_valid = 1'b0;
      check_eq("rd_resp_valid", 64'(bus.client_resp_valid), 64'h4);
      check_eq("rd_resp_data", bus.client_resp_data[63:0], 64'hABCD);
      check_eq("rd_outstanding_0", 64'(outstanding), 64'h0);
      tick();
      check_eq("rd_resp_valid_idle", 64'(bus.client_resp_valid), 64'h0);

      // round robin from a fresh pointer
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b1000;
      rr_exp[3] = 4'b0001; rr_exp[4] = 4'b0010; rr_exp[5] = 4'b1000;
      set_client(0, 1'b1, 1'b1, 64'h000, 64'h10);
      set_client(1, 1'b1, 1'b1, 64'h100, 64'h11);
      set_client(3, 1'b1, 1'b1, 64'h300, 64'h13);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check_eq($sformatf("rr_grant_%0d", c), 64'(bus.client_req_grant), 64'(rr_exp[c]));
         tick();
         check_eq($sformatf("rr_addr_%0d", c), bus.mem_req_addr,
                  (rr_exp[c] == 4'b0001) ? 64'h000 : (rr_exp[c] == 4'b0010) ? 64'h100 : 64'h300);
      end
      clear_clients();
      check_eq("rr_outstanding", 64'(outstanding), 64'h0);
      tick();

      // backpressure: pointer is back at 0
      bus.mem_req_ready = 1'b0;
      set_client(0, 1'b1, 1'b1, 64'h1000, 64'h20);
      set_client(1, 1'b1, 1'b1, 64'h1100, 64'h21);
      @(negedge clk);
      check_eq("bp_first_grant", 64'(bus.client_req_grant), 64'h1);
      tick();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_eq($sformatf("bp_grant_%0d", c), 64'(bus.client_req_grant), 64'h0);
         check_eq($sformatf("bp_addr_%0d", c), bus.mem_req_addr, 64'h1000);
         check_eq($sformatf("bp_valid_%0d", c), 64'(bus.mem_req_valid), 64'h1);
         tick();
      end
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_release_grant", 64'(bus.client_req_grant), 64'h2);
      tick();
      clear_clients();
      check_eq("bp_release_addr", bus.mem_req_addr, 64'h1100);
      tick();

      // tag full: 16 reads from client 0
      set_client(0, 1'b1, 1'b0, 64'h2000, 64'h0);
      for (int c = 0; c < TD; c++) begin
         @(negedge clk);
         check_eq($sformatf("full_fill_grant_%0d", c), 64'(bus.client_req_grant), 64'h1);
         tick();
      end
      clear_clients();
      set_client(1, 1'b1, 1'b0, 64'h2100, 64'h0);
      set_client(2, 1'b1, 1'b1, 64'h2200, 64'h0);
      @(negedge clk);
      check_eq("full_outstanding", 64'(outstanding), 64'd16);
      check_eq("full_write_grant", 64'(bus.client_req_grant), 64'h4);
      tick();
      set_client(2, 1'b0, 1'b0, 64'h0, 64'h0);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = DW'(64'h55);
      @(negedge clk);
      check_eq("full_read_blocked_on_pop", 64'(bus.client_req_grant), 64'h0);
      tick();
      bus.mem_resp_valid = 1'b0;
      @(negedge clk);
      check_eq("full_after_pop_outstanding", 64'(outstanding), 64'd15);
      check_eq("full_read_granted", 64'(bus.client_req_grant), 64'h2);
      tick();
      clear_clients();
      check_eq("full_refilled", 64'(outstanding), 64'd16);
      for (int c = 0; c < TD; c++) begin
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = DW'(64'(c));
         tick();
         bus.mem_resp_valid = 1'b0;
         check_eq($sformatf("drain_resp_%0d", c), 64'(bus.client_resp_valid),
                  (c == TD-1) ? 64'h2 : 64'h1);
      end
      check_eq("drain_outstanding", 64'(outstanding), 64'h0);
      check_eq("drain_no_orphan", 64'(orphan_err), 64'h0);

      // response ordering and orphan; pointer sits at 2
      set_client(3, 1'b1, 1'b0, 64'h3000, 64'h0);
      @(negedge clk);
      check_eq("ord_grant3", 64'(bus.client_req_grant), 64'h8);
      tick();
      clear_clients();
      set_client(0, 1'b1, 1'b0, 64'h3100, 64'h0);
      @(negedge clk);
      check_eq("ord_grant0", 64'(bus.client_req_grant), 64'h1);
      tick();
      clear_clients();
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = DW'(64'h1111);
      tick();
      bus.mem_resp_data  = DW'(64'h2222);
      check_eq("ord_d1_valid", 64'(bus.client_resp_valid), 64'h8);
      check_eq("ord_d1_data", bus.client_resp_data[63:0], 64'h1111);
      tick();
      bus.mem_resp_data  = DW'(64'h3333);
      check_eq("ord_d2_valid", 64'(bus.client_resp_valid), 64'h1);
      check_eq("ord_d2_data", bus.client_resp_data[63:0], 64'h2222);
      tick();
      bus.mem_resp_valid = 1'b0;
      check_eq("orphan_no_resp", 64'(bus.client_resp_valid), 64'h0);
      check_eq("orphan_set", 64'(orphan_err), 64'h1);
      tick();
      check_eq("orphan_sticky", 64'(orphan_err), 64'h1);

      // reset mid-flight with 3 reads outstanding and a live request
      set_client(2, 1'b1, 1'b0, 64'h4000, 64'h0);
      tick();
      tick();
      tick();
      clear_clients();
      check_eq("mid_outstanding_3", 64'(outstanding), 64'h3);
      check_eq("mid_mem_valid", 64'(bus.mem_req_valid), 64'h1);
      rst = 1'b1;
      tick();
      check_eq("mid_rst_outstanding", 64'(outstanding), 64'h0);
      check_eq("mid_rst_mem_valid", 64'(bus.mem_req_valid), 64'h0);
      check_eq("mid_rst_mem_addr", bus.mem_req_addr, 64'h0);
      check_eq("mid_rst_orphan", 64'(orphan_err), 64'h0);
      check_eq("mid_rst_resp", 64'(bus.client_resp_valid), 64'h0);
      rst = 1'b0;
      set_client(0, 1'b1, 1'b1, 64'h5000, 64'h0);
      set_client(3, 1'b1, 1'b1, 64'h5300, 64'h0);
      @(negedge clk);
      check_eq("mid_next_grant", 64'(bus.client_req_grant), 64'h1);
      tick();
      clear_clients();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/umi_mem_arbiter.md
# umi_mem_arbiter

Parametrised N-client arbiter that merges per-client UMI memory request streams (valid, isWrite, addr, data, as in MemReq) onto a single UMI port, and routes read responses (MemResp) back to the issuing client. It sits between application slots and one shell UMI channel. It generalises the single-client UMI interface to NUM_CLIENTS channels using:
- round-robin fairness,
- a registered issue stage with backpressure,
- an in-order read-tag FIFO.

## Interface
- NUM_CLIENTS, 4, number of client channels (≥2)
- ADDR_WIDTH, 64, request address width (UMI_ADDR_WIDTH)
- DATA_WIDTH, 576, request/response data width (UMI_DATA_WIDTH)
- TAG_DEPTH, 16, max outstanding reads (power of 2)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset: synchronous, active-high
- client_req_valid  in  NUM_CLIENTS  per-client request valid
- client_req_iswrite  in  NUM_CLIENTS  per-client write flag
- client_req_addr  in  NUM_CLIENTS*ADDR_WIDTH  client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- client_req_data  in  NUM_CLIENTS*DATA_WIDTH  client i at [i*DATA_WIDTH +: DATA_WIDTH]
- client_req_grant  out  NUM_CLIENTS  one-hot accept strobe (combinational)
- client_resp_valid  out  NUM_CLIENTS  one-hot read response valid
- client_resp_data  out  DATA_WIDTH  response data, shared by all clients
- mem_req_valid, mem_req_iswrite  out  1 each  issued request
- mem_req_addr  out  ADDR_WIDTH  issued address
- mem_req_data  out  DATA_WIDTH  issued data
- mem_req_ready  in  1  UMI port accepts the current mem_req this cycle
- mem_resp_valid  in  1  read response from UMI; in order; no backpressure
- mem_resp_data  in  DATA_WIDTH  read data
- outstanding  out  $clog2(TAG_DEPTH+1)  reads issued to the tag FIFO and not yet answered
- orphan_err  out  1  sticky; set when a response arrives with no outstanding read

## Operation
- **Issue register.** The issue register (mem_req_*) is "free" when mem_req_valid=0 or mem_req_ready=1.
- **Eligibility.** Client i is eligible when client_req_valid[i]=1 and, if client_req_iswrite[i]=1 is false (a read), the tag FIFO is not full. A read is blocked when the FIFO is full, even if a pop occurs in the same cycle. Writes ignore FIFO state.
- **Arbitration.** When the issue register is free, exactly one eligible client is granted: the first eligible index at or after rr_ptr, searching upward modulo NUM_CLIENTS. client_req_grant is 0 otherwise.
- **On grant to client i:**
  - the client's fields are loaded into mem_req_* and mem_req_valid is set;
  - rr_ptr becomes (i+1) mod NUM_CLIENTS;
  - for a read, i is pushed into the tag FIFO.
- **Clearing the issue register.** If the register is free but no client is granted, mem_req_valid is cleared next cycle. The mem_req_* fields must hold stable while mem_req_valid=1 and mem_req_ready=0.
- **Read responses.** On mem_resp_valid with the FIFO non-empty, the head is popped. Next cycle, client_resp_valid[head]=1 and client_resp_data=mem_resp_data. Clients must accept responses unconditionally.
- **Orphan responses.** On mem_resp_valid with the FIFO empty, the response is dropped and orphan_err is set. orphan_err clears only on rst.
- **Outstanding count.** outstanding = FIFO occupancy. A push and a pop in the same cycle leave it unchanged.

## Timing
- Reset values: all outputs 0, rr_ptr=0, FIFO empty. Any in-flight request or tag is discarded.
- rst asserted mid-operation takes effect at the next edge. The environment must also reset the UMI side; responses arriving after reset are orphans.
- Request latency: grant in cycle T gives mem_req_valid=1 in T+1.
- Throughput: with mem_req_ready held at 1, one request per cycle is sustained.
- Response latency: mem_resp_valid in cycle T gives client_resp_valid in T+1.
- client_resp_valid is 0 in cycles with no response.
- Grant is combinational from client_req_valid, client_req_iswrite, mem_req_ready, mem_req_valid, FIFO full and rr_ptr. There is no combinational path from mem_resp_* to grant.
- The FIFO full flag is taken from registered occupancy (pre-pop).

## Test plan
- **Single read.** After reset, client 2 issues a read to addr 0x40; mem_req_ready=1.
  - client_req_grant=4'b0100 in T;
  - mem_req_valid=1, mem_req_addr=0x40 in T+1; outstanding=1;
  - mem_resp_valid with data 0xABCD in cycle U → client_resp_valid=4'b0100, data=0xABCD in U+1; outstanding=0.
- **Round robin.** Clients 0, 1 and 3 hold writes continuously; mem_req_ready=1.
  - Grant order is 0,1,3,0,1,3, one per cycle;
  - no reads are issued, so outstanding stays 0.
- **Backpressure.** mem_req_ready=0 for 5 cycles while clients 0 and 1 are both valid.
  - mem_req_* stay frozen on client 0's request; client_req_grant=0 throughout;
  - on the cycle mem_req_ready=1, client 1 is granted.
- **Tag full.** TAG_DEPTH=16; 16 reads are issued with no responses.
  - outstanding=16; a further read from client 1 is not granted; a write from client 2 is granted;
  - after one response, the read is granted the following cycle.
- **Orphan / response ordering.** Reads from clients 3 then 0 are issued, then responses D1, D2 arrive on back-to-back cycles.
  - D1 goes to client 3 and D2 to client 0;
  - a third response sets orphan_err=1 and raises no client_resp_valid.
- **Reset mid-flight.** rst is asserted with outstanding=3 and mem_req_valid=1.
  - Next cycle all outputs are 0 and outstanding=0;
  - the next grant starts from client 0.
